// File: rtl/tile_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tile_seq_pkg
// Description : Shared types and helpers for the tile sequencer slice.
//               - seq_state_e : sequencer FSM states
//               - tile_cmd_t  : one tile job {w, x, out} at the default
//                               address width
//               - fifo_ptr_w / fifo_cnt_w : command FIFO pointer and
//                               occupancy widths for a given depth
// Revision    : 1.0 - initial release
// ============================================================================
package tile_seq_pkg;

    localparam int TILE_ADDR_W = 13;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD       = 4'd1,
        S_WAIT_LOAD  = 4'd2,
        S_COMP       = 4'd3,
        S_WAIT_COMP  = 4'd4,
        S_STORE      = 4'd5,
        S_WAIT_STORE = 4'd6,
        S_DONE       = 4'd7,
        S_ERROR      = 4'd8
    } seq_state_e;

    typedef struct packed {
        logic [TILE_ADDR_W-1:0] w;
        logic [TILE_ADDR_W-1:0] x;
        logic [TILE_ADDR_W-1:0] out;
    } tile_cmd_t;

    // Read/write pointer width; depth is a power of two so pointers wrap
    // naturally.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy needs one extra bit to represent "exactly full".
    function automatic int fifo_cnt_w(input int depth);
        return fifo_ptr_w(depth) + 1;
    endfunction

endpackage : tile_seq_pkg
`default_nettype wire

// File: rtl/tile_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tile_cmd_fifo
// Description : Synchronous FIFO holding tile job commands. Push is ignored
//               when full, pop is ignored when empty; a simultaneous push
//               and pop keeps the occupancy unchanged. head_o always shows
//               the oldest entry (valid when !empty_o).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               push_i/push_data_i - write request and entry
//               pop_i              - remove the head entry
//               head_o             - oldest entry
//               full_o, empty_o    - occupancy flags
//               count_o            - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module tile_cmd_fifo
    import tile_seq_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = tile_cmd_t
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push_i,
    input  ENTRY_T                          push_data_i,
    input  logic                            pop_i,
    output ENTRY_T                          head_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [fifo_cnt_w(DEPTH)-1:0]    count_o
);

    localparam int c_ptr_w = fifo_ptr_w(DEPTH);
    localparam int c_cnt_w = fifo_cnt_w(DEPTH);

    ENTRY_T               mem_q [DEPTH];
    logic [c_ptr_w-1:0]   wr_ptr_q;
    logic [c_ptr_w-1:0]   rd_ptr_q;
    logic [c_cnt_w-1:0]   count_q;

    logic                 w_push;
    logic                 w_pop;

    assign full_o  = (count_q == c_cnt_w'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i  && !empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + c_cnt_w'(1);
                2'b01:   count_q <= count_q - c_cnt_w'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset: stale entries are never visible because
    // the occupancy count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : tile_cmd_fifo
`default_nettype wire

// File: rtl/tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tile_sequencer
// Description : Command-driven load -> compute -> store sequencer placed in
//               front of systolic_wrapper. Jobs are queued in a small FIFO,
//               then each job pulses start_* and waits for the matching
//               done_* per phase while holding its base addresses. Counts
//               completed jobs; a per-phase watchdog traps in ERROR, which
//               only rst leaves.
// Ports       : clk, rst                      - clock, sync active-high reset
//               cmd_valid/cmd_ready           - job command handshake
//               cmd_base_w/x/out              - job addresses
//               start_load/compute/store      - one-cycle phase start pulses
//               done_load/compute/store       - phase completion inputs
//               base_addr_w/x/out             - addresses of current job
//               busy                          - sequencer not idle
//               job_done                      - one pulse per finished job
//               jobs_completed                - wrapping job counter
//               error                         - sticky watchdog timeout
// Revision    : 1.0 - initial release
// ============================================================================
module tile_sequencer
    import tile_seq_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 13,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_base_w,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_base_x,
    input  logic [ADDRESS_WIDTH-1:0]  cmd_base_out,
    output logic                      start_load,
    output logic                      start_compute,
    output logic                      start_store,
    input  logic                      done_load,
    input  logic                      done_compute,
    input  logic                      done_store,
    output logic [ADDRESS_WIDTH-1:0]  base_addr_w,
    output logic [ADDRESS_WIDTH-1:0]  base_addr_x,
    output logic [ADDRESS_WIDTH-1:0]  base_addr_out,
    output logic                      busy,
    output logic                      job_done,
    output logic [CNT_WIDTH-1:0]      jobs_completed,
    output logic                      error
);

    // Same layout as tile_cmd_t, sized to this instance's address width.
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] w;
        logic [ADDRESS_WIDTH-1:0] x;
        logic [ADDRESS_WIDTH-1:0] out;
    } cmd_entry_t;

    // The watchdog only ever holds 0 .. TIMEOUT_CYCLES-1: reaching the last
    // value without a done is the timeout itself.
    localparam int              c_wd_w      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              c_wd_enable = (TIMEOUT_CYCLES != 0);
    localparam logic [c_wd_w-1:0] c_wd_last =
        c_wd_w'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    seq_state_e                     state_q;
    seq_state_e                     state_d;
    logic [c_wd_w-1:0]              wdog_q;
    logic [c_wd_w-1:0]              wdog_d;
    cmd_entry_t                     cur_q;
    logic [CNT_WIDTH-1:0]           jobs_q;
    logic                           busy_q;
    logic                           error_q;

    cmd_entry_t                     w_push_data;
    cmd_entry_t                     w_head;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_fifo_full;
    logic                           w_fifo_empty;
    logic [fifo_cnt_w(FIFO_DEPTH)-1:0] w_fifo_count;
    logic                           w_wd_expired;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    assign cmd_ready   = !w_fifo_full && (state_q != S_ERROR);
    assign w_push      = cmd_valid && cmd_ready;
    assign w_push_data = '{w: cmd_base_w, x: cmd_base_x, out: cmd_base_out};
    // Popping is tied to the registered occupancy, so a command pushed in
    // this cycle is never popped in the same cycle.
    assign w_pop       = (state_q == S_IDLE) && !w_fifo_empty;

    tile_cmd_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_T (cmd_entry_t)
    ) u_cmd_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .count_o     (w_fifo_count)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM: next state, watchdog and phase pulses
    // ------------------------------------------------------------------
    assign w_wd_expired = c_wd_enable && (wdog_q == c_wd_last);

    always_comb begin
        state_d       = state_q;
        wdog_d        = wdog_q;
        start_load    = 1'b0;
        start_compute = 1'b0;
        start_store   = 1'b0;
        job_done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_fifo_count != '0) begin
                    state_d = S_LOAD;
                end
            end

            // Start states clear the watchdog so each WAIT begins at zero.
            // Any done_* seen here is ignored by construction.
            S_LOAD: begin
                start_load = 1'b1;
                wdog_d     = '0;
                state_d    = S_WAIT_LOAD;
            end

            S_WAIT_LOAD: begin
                if (done_load) begin
                    state_d = S_COMP;
                end else if (w_wd_expired) begin
                    state_d = S_ERROR;
                end else begin
                    wdog_d = wdog_q + c_wd_w'(1);
                end
            end

            S_COMP: begin
                start_compute = 1'b1;
                wdog_d        = '0;
                state_d       = S_WAIT_COMP;
            end

            S_WAIT_COMP: begin
                if (done_compute) begin
                    state_d = S_STORE;
                end else if (w_wd_expired) begin
                    state_d = S_ERROR;
                end else begin
                    wdog_d = wdog_q + c_wd_w'(1);
                end
            end

            S_STORE: begin
                start_store = 1'b1;
                wdog_d      = '0;
                state_d     = S_WAIT_STORE;
            end

            S_WAIT_STORE: begin
                if (done_store) begin
                    state_d = S_DONE;
                end else if (w_wd_expired) begin
                    state_d = S_ERROR;
                end else begin
                    wdog_d = wdog_q + c_wd_w'(1);
                end
            end

            S_DONE: begin
                job_done = 1'b1;
                state_d  = S_IDLE;
            end

            S_ERROR: begin
                state_d = S_ERROR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wdog_q  <= '0;
            cur_q   <= '0;
            jobs_q  <= '0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            if (w_pop) begin
                cur_q <= w_head;
            end
            if (state_q == S_DONE) begin
                jobs_q <= jobs_q + CNT_WIDTH'(1);
            end
            // Registered alongside the state so both flags line up with
            // the state they describe.
            busy_q  <= (state_d != S_IDLE);
            error_q <= (state_d == S_ERROR);
        end
    end

    assign base_addr_w    = cur_q.w;
    assign base_addr_x    = cur_q.x;
    assign base_addr_out  = cur_q.out;
    assign jobs_completed = jobs_q;
    assign busy           = busy_q;
    assign error          = error_q;

endmodule : tile_sequencer
`default_nettype wire

// File: tb/tb_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_sequencer
// Description : Self-checking bench for tile_sequencer. A queue-based job
//               model predicts every output each cycle; directed scenarios
//               add hand-computed latency and value expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_sequencer;

    localparam int AW    = 13;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;
    localparam int CW    = 16;
    localparam int K     = 3;   // done returned K cycles after each start

    typedef struct packed {
        logic [AW-1:0] w;
        logic [AW-1:0] x;
        logic [AW-1:0] o;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_w, cmd_x, cmd_o;
    logic          start_load, start_compute, start_store;
    logic          done_load, done_compute, done_store;
    logic [AW-1:0] base_addr_w, base_addr_x, base_addr_out;
    logic          busy, job_done, error;
    logic [CW-1:0] jobs_completed;

    logic [2:0]    man_done  = 3'b000;
    logic [2:0]    auto_done = 3'b000;
    logic [2:0]    auto_mask = 3'b111;

    assign done_load    = man_done[0] | auto_done[0];
    assign done_compute = man_done[1] | auto_done[1];
    assign done_store   = man_done[2] | auto_done[2];

    always #5 clk = ~clk;

    tile_sequencer #(
        .ADDRESS_WIDTH  (AW),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_base_w     (cmd_w),
        .cmd_base_x     (cmd_x),
        .cmd_base_out   (cmd_o),
        .start_load     (start_load),
        .start_compute  (start_compute),
        .start_store    (start_store),
        .done_load      (done_load),
        .done_compute   (done_compute),
        .done_store     (done_store),
        .base_addr_w    (base_addr_w),
        .base_addr_x    (base_addr_x),
        .base_addr_out  (base_addr_out),
        .busy           (busy),
        .job_done       (job_done),
        .jobs_completed (jobs_completed),
        .error          (error)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Wrapper responder: returns done K cycles after a start it is allowed
    // to answer.
    // ------------------------------------------------------------------
    int due [3] = '{-100, -100, -100};
    always @(posedge clk) begin
        logic [2:0] st;
        st = {start_store, start_compute, start_load};
        for (int p = 0; p < 3; p++)
            if (st[p] && auto_mask[p]) due[p] = cyc + K;
        #1;
        for (int p = 0; p < 3; p++)
            auto_done[p] = (cyc == due[p]);
    end

    // ------------------------------------------------------------------
    // Job-level model: queue of commands, current job, phase index
    // (-1 idle, 0..2 load/compute/store, 3 finished), whether the phase is
    // in its start cycle, and the number of fruitless wait cycles.
    // ------------------------------------------------------------------
    cmd_t        mq[$];
    cmd_t        m_cur     = '0;
    int          m_phase   = -1;
    bit          m_starting = 1'b0;
    int          m_wait    = 0;
    bit          m_err     = 1'b0;
    int unsigned m_jobs    = 0;
    bit          chk_en    = 1'b0;

    always @(posedge clk) begin
        bit         push;
        cmd_t       inc;
        logic [2:0] dv;
        dv = {done_store, done_compute, done_load};
        if (rst) begin
            mq.delete();
            m_cur = '0; m_phase = -1; m_starting = 1'b0;
            m_wait = 0; m_err = 1'b0; m_jobs = 0;
            chk_en = 1'b1;
        end else begin
            push = cmd_valid && (mq.size() < DEPTH) && !m_err;
            inc  = {cmd_w, cmd_x, cmd_o};
            if (!m_err) begin
                if (m_phase < 0) begin
                    if (mq.size() > 0) begin
                        m_cur = mq.pop_front();
                        m_phase = 0;
                        m_starting = 1'b1;
                    end
                end else if (m_phase == 3) begin
                    m_jobs = m_jobs + 1;
                    m_phase = -1;
                end else if (m_starting) begin
                    m_starting = 1'b0;
                    m_wait = 0;
                end else if (dv[m_phase]) begin
                    m_phase = m_phase + 1;
                    m_starting = (m_phase < 3);
                end else begin
                    m_wait = m_wait + 1;
                    if (TMO != 0 && m_wait == TMO) m_err = 1'b1;
                end
            end
            if (push) mq.push_back(inc);
        end
    end

    // ------------------------------------------------------------------
    // Compare process plus event bookkeeping for the directed checks.
    // ------------------------------------------------------------------
    int n_sl = 0, n_sc = 0, n_ss = 0, n_jd = 0;
    int sl_cyc = 0, sc_cyc = 0, ss_cyc = 0, jd_cyc = 0, err_cyc = 0;
    bit err_seen = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [2:0] es;
            es = 3'b000;
            if (m_phase >= 0 && m_phase < 3 && m_starting) es[m_phase] = 1'b1;
            check("start", {start_store, start_compute, start_load}, es);
            check("job_done", job_done, m_phase == 3);
            check("busy", busy, (m_phase >= 0) || m_err);
            check("error", error, m_err);
            check("cmd_ready", cmd_ready, (mq.size() < DEPTH) && !m_err);
            check("base_w", base_addr_w, m_cur.w);
            check("base_x", base_addr_x, m_cur.x);
            check("base_out", base_addr_out, m_cur.o);
            check("jobs_completed", jobs_completed, CW'(m_jobs));
            if (start_load)    begin n_sl++; sl_cyc = cyc; end
            if (start_compute) begin n_sc++; sc_cyc = cyc; end
            if (start_store)   begin n_ss++; ss_cyc = cyc; end
            if (job_done)      begin n_jd++; jd_cyc = cyc; end
            if (error && !err_seen) begin err_seen = 1'b1; err_cyc = cyc; end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_jobs(input int n, input int budget);
        int i;
        i = 0;
        while (n_jd < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("wait_jobs_budget", n_jd >= n, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int push_cyc, s0, s1, s2, i;
        rst = 1'b1; cmd_valid = 1'b0;
        cmd_w = '0; cmd_x = '0; cmd_o = '0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_jobs", jobs_completed, 0);
        check("rst_base_x", base_addr_x, 0);
        check("rst_starts", {start_store, start_compute, start_load}, 3'b000);
        tick(); rst = 1'b0;

        // Single job
        tick(); cmd_valid = 1'b1; cmd_w = 13'h000; cmd_x = 13'h100; cmd_o = 13'h010;
        push_cyc = cyc;
        tick(); cmd_valid = 1'b0;
        wait_jobs(1, 60);
        check("t1_push_to_start", sl_cyc - push_cyc, 2);
        check("t1_load_to_comp", sc_cyc - sl_cyc, 4);
        check("t1_comp_to_store", ss_cyc - sc_cyc, 4);
        check("t1_job_len", jd_cyc - sl_cyc, 12);
        check("t1_pulse_counts", {n_sl[7:0], n_sc[7:0], n_ss[7:0], n_jd[7:0]}, 32'h01010101);
        check("t1_base_w", base_addr_w, 13'h000);
        check("t1_base_x", base_addr_x, 13'h100);
        check("t1_base_out", base_addr_out, 13'h010);
        check("t1_jobs", jobs_completed, 1);

        // Three back-to-back commands
        for (int j = 0; j < 3; j++) begin
            tick(); cmd_valid = 1'b1;
            cmd_w = 13'h200 + 13'(j); cmd_x = 13'h300 + 13'(j); cmd_o = 13'h400 + 13'(j);
            check("t2_accept", cmd_ready, 1'b1);
        end
        tick(); cmd_valid = 1'b0;
        wait_jobs(4, 200);
        check("t2_jobs", jobs_completed, 4);
        check("t2_busy_low", busy, 1'b0);
        check("t2_last_base_out", base_addr_out, 13'h402);

        // FIFO fill with done held low
        auto_mask = 3'b000;
        for (int j = 0; j < 5; j++) begin
            tick(); cmd_valid = 1'b1;
            cmd_w = 13'h500 + 13'(j); cmd_x = 13'h600 + 13'(j); cmd_o = 13'h700 + 13'(j);
            check("t3_accept", cmd_ready, 1'b1);
        end
        tick(); cmd_valid = 1'b0;
        check("t3_full_not_ready", cmd_ready, 1'b0);
        tick(); man_done = 3'b001; auto_mask = 3'b111;
        tick(); man_done = 3'b000;
        wait_jobs(9, 400);
        check("t3_jobs", jobs_completed, 9);
        check("t3_last_base_w", base_addr_w, 13'h504);

        // Spurious done inputs
        auto_mask = 3'b000;
        s1 = n_sc;
        tick(); cmd_valid = 1'b1; cmd_w = 13'h0AA; cmd_x = 13'h0BB; cmd_o = 13'h0CC;
        tick(); cmd_valid = 1'b0;
        tick(); man_done = 3'b001;
        check("t4_start_load_cycle", start_load, 1'b1);
        tick(); man_done = 3'b100;
        tick(); man_done = 3'b000;
        tick();
        check("t4_no_early_compute", n_sc, s1);
        check("t4_still_busy", busy, 1'b1);
        man_done = 3'b001; auto_mask = 3'b111;
        tick(); man_done = 3'b000;
        wait_jobs(10, 60);
        check("t4_load_to_comp", sc_cyc - sl_cyc, 4);
        check("t4_jobs", jobs_completed, 10);

        // Reset during WAIT_COMP with two queued jobs
        auto_mask = 3'b000;
        for (int j = 0; j < 3; j++) begin
            tick(); cmd_valid = 1'b1;
            cmd_w = 13'h111 * 13'(j + 1); cmd_x = 13'h0F0; cmd_o = 13'h00F;
        end
        tick(); cmd_valid = 1'b0; man_done = 3'b001;
        tick(); man_done = 3'b000;
        check("t5_start_compute", start_compute, 1'b1);
        tick();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        check("t5_busy", busy, 1'b0);
        check("t5_ready", cmd_ready, 1'b1);
        check("t5_jobs", jobs_completed, 0);
        check("t5_base_w", base_addr_w, 0);
        check("t5_error", error, 1'b0);
        s0 = n_sl;
        repeat (4) tick();
        check("t5_queue_dropped", n_sl, s0);

        // Watchdog on compute phase
        auto_mask = 3'b101;
        tick(); cmd_valid = 1'b1; cmd_w = 13'h123; cmd_x = 13'h456; cmd_o = 13'h789;
        tick(); cmd_valid = 1'b0;
        i = 0;
        while (!err_seen && i < 60) begin
            @(negedge clk);
            i++;
        end
        check("t6_error_seen", err_seen, 1'b1);
        check("t6_timeout_len", err_cyc - sc_cyc, 9);
        check("t6_error", error, 1'b1);
        check("t6_not_ready", cmd_ready, 1'b0);
        s0 = n_sl; s1 = n_sc; s2 = n_ss;
        tick(); cmd_valid = 1'b1;
        repeat (5) tick();
        cmd_valid = 1'b0;
        check("t6_no_starts", {n_sl[7:0], n_sc[7:0], n_ss[7:0]}, {s0[7:0], s1[7:0], s2[7:0]});
        check("t6_still_error", error, 1'b1);
        check("t6_jobs", jobs_completed, 0);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        check("t6_rst_error", error, 1'b0);
        check("t6_rst_ready", cmd_ready, 1'b1);
        check("t6_rst_busy", busy, 1'b0);
        repeat (4) tick();
        check("t6_no_restart", n_sl, s0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule : tb_tile_sequencer
`default_nettype wire
